// File: rtl/vector_floating_point_divide_unit_iterative_pkg.sv
// Shared types and constants for the iterative vector FP32 divider.
// Holds the binary32 field layout, operand classes, exception-flag layout,
// the divider FSM states and an operand classification helper.
package vector_floating_point_divide_unit_iterative_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp32_t;

  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fp_class_t;

  // Bit order matches the RISC-V fflags CSR: {NV,DZ,OF,UF,NX}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} divide_state_t;

  localparam logic [31:0] FP32_CANONICAL_NAN  = 32'h7FC00000;
  localparam int          FP32_BIAS           = 127;
  localparam int          FP32_DIV_ITERATIONS = 26;

  // Subnormals (exponent 0) classify as ZERO: they are flushed silently.
  function automatic fp_class_t fp32_classify(input fp32_t x);
    fp_class_t c;
    if (x.exponent == 8'h00)      c = ZERO;
    else if (x.exponent == 8'hFF) c = (x.mantissa == 23'd0) ? INF :
                                      (x.mantissa[22] ? QNAN : SNAN);
    else                          c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fp32_divide_lane.sv
// One binary32 divide lane: restoring radix-2 mantissa divider with
// round-to-nearest-even packing.
// Ports:
//   clock, reset    - clock, async active-high reset
//   start           - latch op_a/op_b, classify, initialise divider
//   step            - produce one quotient bit
//   round_en        - normalise/round/pack into result and flags
//   op_a, op_b      - dividend / divisor (already swapped for vfrdiv)
//   result, flags   - registered quotient and exception flags
module fp32_divide_lane
  import vector_floating_point_divide_unit_iterative_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic        round_en,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result,
  output fflags_t     flags
);

  fp32_t     a, b;
  fp_class_t ca, cb;
  logic      s;

  assign a  = op_a;
  assign b  = op_b;
  assign ca = fp32_classify(a);
  assign cb = fp32_classify(b);
  assign s  = a.sign ^ b.sign;

  // Special-operand resolution, computed at accept time.
  logic        sp;
  logic [31:0] sp_res;
  fflags_t     sp_flags;

  always_comb begin
    sp       = 1'b1;
    sp_res   = {s, 31'd0};
    sp_flags = '0;
    if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
      sp_res      = FP32_CANONICAL_NAN;
      sp_flags.nv = (ca == SNAN) || (cb == SNAN);
    end else if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
      sp_res      = FP32_CANONICAL_NAN;
      sp_flags.nv = 1'b1;
    end else if (ca == INF) begin
      sp_res = {s, 8'hFF, 23'd0};
    end else if (cb == ZERO) begin
      sp_res      = {s, 8'hFF, 23'd0};
      sp_flags.dz = 1'b1;
    end else if (ca == ZERO || cb == INF) begin
      sp_res = {s, 31'd0};
    end else begin
      sp = 1'b0;
    end
  end

  // Datapath state
  logic        sign_q;
  logic [9:0]  exp_q;     // unbiased difference + bias, two's complement
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [25:0] quo_q;
  logic        sp_q;
  logic [31:0] sp_res_q;
  fflags_t     sp_flags_q;

  // Remainder stays below 2*divisor, so a 26-bit compare is enough.
  logic [25:0] diff;
  assign diff = {1'b0, rem_q} - {2'b00, mb_q};

  // Normalise, round to nearest even, range check.
  logic        norm, rbit, sticky, up, inexact;
  logic [25:0] m_full;
  logic [23:0] mant;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic [9:0]  e_pre, e_fin;
  logic [31:0] rnd_res;
  fflags_t     rnd_flags;

  always_comb begin
    norm      = quo_q[25];
    m_full    = norm ? quo_q : {quo_q[24:0], 1'b0};
    e_pre     = exp_q - {9'd0, ~norm};
    mant      = m_full[25:2];
    rbit      = m_full[1];
    sticky    = m_full[0] | (|rem_q);
    up        = rbit & (sticky | mant[0]);
    mant_r    = {1'b0, mant} + {24'd0, up};
    e_fin     = e_pre + {9'd0, mant_r[24]};
    frac      = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    inexact   = rbit | sticky;
    rnd_flags = '0;
    if ($signed(e_fin) >= 10'sd255) begin
      rnd_res      = {sign_q, 8'hFF, 23'd0};
      rnd_flags.of = 1'b1;
      rnd_flags.nx = 1'b1;
    end else if ($signed(e_fin) <= 10'sd0) begin
      rnd_res      = {sign_q, 31'd0};
      rnd_flags.uf = 1'b1;
      rnd_flags.nx = 1'b1;
    end else begin
      rnd_res      = {sign_q, e_fin[7:0], frac};
      rnd_flags.nx = inexact;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sp_q       <= 1'b0;
      sp_res_q   <= '0;
      sp_flags_q <= '0;
      result     <= '0;
      flags      <= '0;
    end else if (start) begin
      sign_q     <= s;
      exp_q      <= {2'b00, a.exponent} - {2'b00, b.exponent} + 10'(FP32_BIAS);
      mb_q       <= {1'b1, b.mantissa};
      rem_q      <= {2'b01, a.mantissa};
      quo_q      <= '0;
      sp_q       <= sp;
      sp_res_q   <= sp_res;
      sp_flags_q <= sp_flags;
    end else if (step) begin
      if (!diff[25]) begin
        rem_q <= {diff[23:0], 1'b0};
        quo_q <= {quo_q[24:0], 1'b1};
      end else begin
        rem_q <= {rem_q[23:0], 1'b0};
        quo_q <= {quo_q[24:0], 1'b0};
      end
    end else if (round_en) begin
      result <= sp_q ? sp_res_q   : rnd_res;
      flags  <= sp_q ? sp_flags_q : rnd_flags;
    end
  end

endmodule

// File: rtl/vector_floating_point_divide_unit_iterative.sv
// Iterative vector FP32 divider: all SEW=32 lanes of a VLEN vector divide in
// parallel, one quotient bit per lane per cycle, valid/ready on both sides.
// Ports:
//   clock, reset           - clock, async active-high reset
//   flush                  - abort any operation, back to IDLE
//   in_valid/in_ready      - operand handshake
//   reverse                - 0: vd=vs2/vs1, 1: vd=vs1/vs2
//   vs2, vs1               - dividend / divisor vectors
//   out_valid/out_ready    - result handshake
//   vd, fflags             - quotient vector, OR of lane flags {NV,DZ,OF,UF,NX}
module vector_floating_point_divide_unit_iterative
  import vector_floating_point_divide_unit_iterative_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int SEW  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            reverse,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] vd,
  output logic [4:0]      fflags
);

  localparam int NUM_LANES = VLEN / SEW;

  if (SEW != 32) begin : g_sew_chk
    $error("vector divider supports SEW=32 only");
  end
  if (VLEN % 32 != 0) begin : g_vlen_chk
    $error("VLEN must be a multiple of 32");
  end

  divide_state_t state_q, state_d;
  logic [4:0]    iter_q;
  logic          ready_q;
  logic          start_stb, step_stb, round_stb;

  // Holds in_ready low for the first cycle out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= (state_q == DIVIDE) ? iter_q + 5'd1 : 5'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_stb = 1'b0;
    step_stb  = 1'b0;
    round_stb = 1'b0;
    case (state_q)
      IDLE: if (in_valid && ready_q) begin
        start_stb = 1'b1;
        state_d   = DIVIDE;
      end
      DIVIDE: begin
        step_stb = 1'b1;
        if (iter_q == 5'(FP32_DIV_ITERATIONS - 1)) state_d = ROUND;
      end
      ROUND: begin
        round_stb = 1'b1;
        state_d   = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush beats every other request, including an accept in IDLE
    if (flush) begin
      state_d   = IDLE;
      start_stb = 1'b0;
      step_stb  = 1'b0;
      round_stb = 1'b0;
    end
  end

  assign in_ready  = ready_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  logic    [NUM_LANES-1:0][31:0] op_a, op_b, lane_res;
  fflags_t [NUM_LANES-1:0]       lane_flags;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign op_a[i] = reverse ? vs1[32*i +: 32] : vs2[32*i +: 32];
    assign op_b[i] = reverse ? vs2[32*i +: 32] : vs1[32*i +: 32];
    assign vd[32*i +: 32] = lane_res[i];

    fp32_divide_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .start    (start_stb),
      .step     (step_stb),
      .round_en (round_stb),
      .op_a     (op_a[i]),
      .op_b     (op_b[i]),
      .result   (lane_res[i]),
      .flags    (lane_flags[i])
    );
  end

  always_comb begin
    fflags = '0;
    for (int i = 0; i < NUM_LANES; i++) fflags = fflags | lane_flags[i];
  end

endmodule

// File: tb/tb_vector_floating_point_divide_unit_iterative.sv
module tb_vector_floating_point_divide_unit_iterative;

  localparam int VLEN = 128;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            reverse = 1'b0;
  logic [VLEN-1:0] vs2 = '0;
  logic [VLEN-1:0] vs1 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [VLEN-1:0] vd;
  logic [4:0]      fflags;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [127:0] vd;
    logic [4:0]   ff;
  } exp_t;
  exp_t sb[$];

  vector_floating_point_divide_unit_iterative #(.VLEN(VLEN), .SEW(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reverse   (reverse),
    .vs2       (vs2),
    .vs1       (vs1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vd        (vd),
    .fflags    (fflags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present one operation, optionally push
  // its expected result. Returns just after the accepting edge.
  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic rev,
                      input logic push, input logic [127:0] evd, input logic [4:0] eff);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("send_in_ready", 128'(in_ready), 128'd1);
    vs2 = a; vs1 = b; reverse = rev; in_valid = 1'b1;
    if (push) begin
      e.vd = evd; e.ff = eff;
      sb.push_back(e);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles to out_valid, then pop the scoreboard and compare.
  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 60);
    check({tag, "_latency"}, 128'(lat), 128'd28);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_vd"},     vd,            e.vd);
      check({tag, "_fflags"}, 128'(fflags),  128'(e.ff));
    end else begin
      check({tag, "_sb_nonempty"}, 128'(sb.size()), 128'd1);
    end
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int n_ov;

    // Reset state
    #12;
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_vd",        vd,              128'd0);
    check("rst_fflags",    128'(fflags),    128'd0);
    @(negedge clock) reset = 1'b0;
    #1 check("rel_in_ready_low", 128'(in_ready), 128'd0);
    @(negedge clock);
    check("rel_in_ready_high", 128'(in_ready), 128'd1);

    // 6/2 on every lane
    send({4{32'h40C00000}}, {4{32'h40000000}}, 1'b0, 1'b1, {4{32'h40400000}}, 5'b00000);
    wait_result("six_by_two");
    pop_out();

    // Mixed lanes incl. 1/3 (inexact)
    send({32'h3F800000, 32'h3F800000, 32'hC0C00000, 32'h3F800000},
         {32'hBF800000, 32'h3F800000, 32'h40000000, 32'h40400000}, 1'b0, 1'b1,
         {32'hBF800000, 32'h3F800000, 32'hC0400000, 32'h3EAAAAAB}, 5'b00001);
    wait_result("one_third");
    pop_out();

    // Reverse operands: vd = vs1/vs2
    send({32'h40000000, 32'h40800000, 32'h40000000, 32'h3F800000},
         {32'hBF800000, 32'h3F800000, 32'h40C00000, 32'h40400000}, 1'b1, 1'b1,
         {32'hBF000000, 32'h3E800000, 32'h40400000, 32'h40400000}, 5'b00000);
    wait_result("reverse");
    pop_out();

    // Specials: 1/+0, 0/0, -inf/2, sNaN/1
    send({32'h7F800001, 32'hFF800000, 32'h00000000, 32'h3F800000},
         {32'h3F800000, 32'h40000000, 32'h00000000, 32'h00000000}, 1'b0, 1'b1,
         {32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7F800000}, 5'b11000);
    wait_result("specials");
    pop_out();

    // Overflow and underflow
    send({32'h40C00000, 32'h40C00000, 32'h00800000, 32'h7F000000},
         {32'h40000000, 32'h40000000, 32'h40000000, 32'h3E800000}, 1'b0, 1'b1,
         {32'h40400000, 32'h40400000, 32'h00000000, 32'h7F800000}, 5'b00111);
    wait_result("of_uf");
    pop_out();

    // Subnormal flush and finite/inf
    send({32'hBF800000, 32'h3F800000, 32'h80000001, 32'h00000001},
         {32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000}, 1'b0, 1'b1,
         {32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000}, 5'b00000);
    wait_result("subnorm_inf");
    pop_out();

    // Backpressure: result held for 10 cycles
    send({4{32'h40C00000}}, {4{32'h40000000}}, 1'b0, 1'b1, {4{32'h40400000}}, 5'b00000);
    wait_result("backpressure");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_vd_stable",  vd,              {4{32'h40400000}});
      check("bp_out_valid",  128'(out_valid), 128'd1);
      check("bp_in_ready",   128'(in_ready),  128'd0);
    end
    pop_out();
    @(negedge clock);
    check("bp_pop_out_valid", 128'(out_valid), 128'd0);
    check("bp_pop_in_ready",  128'(in_ready),  128'd1);

    // Async reset at iteration 12
    send({4{32'h3F800000}}, {4{32'h40400000}}, 1'b0, 1'b0, '0, '0);
    repeat (12) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_vd",        vd,              128'd0);
    check("areset_fflags",    128'(fflags),    128'd0);
    check("areset_out_valid", 128'(out_valid), 128'd0);
    check("areset_in_ready",  128'(in_ready),  128'd0);
    @(negedge clock);
    @(negedge clock) reset = 1'b0;
    #1 check("areset_rel_in_ready_low", 128'(in_ready), 128'd0);
    @(negedge clock);
    check("areset_rel_in_ready_high", 128'(in_ready), 128'd1);
    n_ov = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) n_ov++;
    end
    check("areset_no_result", 128'(n_ov), 128'd0);

    // Flush at iteration 12
    send({4{32'h3F800000}}, {4{32'h40400000}}, 1'b0, 1'b0, '0, '0);
    repeat (12) @(posedge clock);
    @(negedge clock) flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'd0);
    check("flush_in_ready",  128'(in_ready),  128'd1);
    n_ov = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) n_ov++;
    end
    check("flush_no_result", 128'(n_ov), 128'd0);

    send({32'h40C00000, 32'h3F800000, 32'h40C00000, 32'h3F800000},
         {32'h40000000, 32'h40400000, 32'h40000000, 32'h40400000}, 1'b0, 1'b1,
         {32'h40400000, 32'h3EAAAAAB, 32'h40400000, 32'h3EAAAAAB}, 5'b00001);
    wait_result("after_flush");
    pop_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vector_floating_point_divide_unit_iterative.md
Name: vector_floating_point_divide_unit_iterative

Overview:
- Parametrised, multi-cycle successor to the single-cycle registered vector FP divider.
- Divides all SEW=32 lanes of a VLEN-bit vector register in parallel with a radix-2 iterative mantissa divider, one quotient bit per lane per cycle.
- Uses a valid/ready handshake on both sides, supports a reverse-operand mode (vfrdiv), and produces accumulated IEEE-754 exception flags.
- Sits in the vector execution stage between the operand-read pipeline register and the writeback arbiter.

Parameters:
- VLEN, 128: vector register width in bits; must be a multiple of 32.
- SEW, 32: element width; only 32 (binary32) is supported, with an elaboration-time assertion otherwise.
- NUM_LANES, VLEN/SEW: derived localparam; not overridable.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight operation
- in_valid  input  1  operands valid
- in_ready  output  1  unit can accept an operation
- reverse  input  1  0: vd=vs2/vs1; 1: vd=vs1/vs2
- vs2  input  VLEN  dividend vector (lane i = bits 32i+31:32i)
- vs1  input  VLEN  divisor vector
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- vd  output  VLEN  quotient vector
- fflags  output  5  {NV,DZ,OF,UF,NX}, OR across lanes, valid with out_valid

Behaviour:
Reset:
- Reset is asynchronous and active-high. While asserted: FSM=IDLE, in_ready=0, out_valid=0, vd=0, fflags=0, all lane registers 0.
- in_ready rises the first cycle after reset deasserts.

FSM:
- IDLE: in_ready=1. If in_valid, latch operands (swap if reverse), unpack and classify each lane, then go to DIVIDE with iter=0.
- DIVIDE: 26 cycles. Each cycle, each lane produces one quotient bit (24 mantissa + guard + round) by restoring subtract/shift. On iter==25, go to ROUND.
- ROUND (1 cycle):
  - sticky = OR of the final remainder.
  - Normalise (shift left 1 if the quotient MSB is 0, decrementing the exponent).
  - Round to nearest, ties to even.
  - Apply exponent bias; write vd and fflags; go to DONE.
- DONE: out_valid=1, vd/fflags held stable. On out_ready, go to IDLE (out_valid drops the next cycle).

Latency and throughput:
- Accept to out_valid is 28 cycles.
- A new operation cannot be accepted in the same cycle a result is popped. Throughput is 1 operation per 29 cycles minimum.

Special cases:
- Resolved at accept; the lane result is forced in ROUND, and the iteration still runs so latency is uniform.
- Any NaN operand gives 0x7FC00000. NV is set only for a signalling NaN, 0/0, or inf/inf.
- x/0 with x finite and non-zero gives ±inf and sets DZ.
- inf/finite gives ±inf. finite/inf gives ±0.
- Subnormal inputs are flushed to ±0 before classification, with no flag.
- Overflow (biased exponent ≥ 255) gives ±inf and sets OF and NX.
- Underflow (biased exponent ≤ 0) gives ±0 and sets UF and NX.
- Result sign = XOR of the operand signs, including for zero and inf results.

Other rules:
- flush in any state: return to IDLE next cycle, out_valid=0, no result emitted. flush takes priority over out_ready and in_valid.
- in_valid while not IDLE is ignored; the producer must hold in_valid until in_ready.
- out_valid held with out_ready=0 keeps vd stable indefinitely.

Decomposition:
- dragonfang_floating_point_pkg gains:
  - fp32_t struct {sign, exponent[7:0], mantissa[22:0]}
  - fp_class_t enum {ZERO, NORMAL, INF, QNAN, SNAN}
  - localparams FP32_CANONICAL_NAN=32'h7FC00000, FP32_BIAS=127, FP32_DIV_ITERATIONS=26
  - fflags_t struct
- dragonfang_pkg gains divide_state_t {IDLE, DIVIDE, ROUND, DONE}.
- One sub-module, fp32_divide_lane: per-lane datapath (remainder/quotient/exponent registers, iteration step, round/pack), driven by shared start/step/round strobes from the top-level FSM. It is generated NUM_LANES times.

Test Plan:
- All lanes 0x40C00000 / 0x40000000 (6.0/2.0), reverse=0 -> out_valid at cycle 28 after accept, every lane 0x40400000, fflags=0.
- Lane 0: 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, NX=1. Same operands with reverse=1 -> 0x40400000, fflags=0.
- Lane 0: 1.0/+0 -> 0x7F800000, DZ. Lane 1: 0/0 -> 0x7FC00000, NV. Lane 2: 0xFF800000/0x40000000 -> 0xFF800000. Lane 3: sNaN 0x7F800001 / 1.0 -> 0x7FC00000, NV. Expect fflags=5'b11000.
- 0x7F000000 / 0x3E800000 -> 0x7F800000 with OF|NX. 0x00800000 / 0x40000000 -> 0x00000000 with UF|NX.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> vd stable, in_ready=0. out_ready=1 -> IDLE, in_ready=1 one cycle later.
- Reset asserted at iteration 12 -> outputs 0 immediately (asynchronously), with no result after release. flush at iteration 12 -> IDLE next cycle, no out_valid, and the next operation completes correctly.
